// File: rtl/lcd_timing_pkg.sv
// Shared timing defaults, bus widths and reader FSM encoding for the LCD frame reader.
package lcd_timing_pkg;

  localparam int unsigned DEF_H_SYNC   = 41;
  localparam int unsigned DEF_H_BP     = 2;
  localparam int unsigned DEF_H_ACTIVE = 480;
  localparam int unsigned DEF_H_FP     = 2;
  localparam int unsigned DEF_V_SYNC   = 10;
  localparam int unsigned DEF_V_BP     = 2;
  localparam int unsigned DEF_V_ACTIVE = 272;
  localparam int unsigned DEF_V_FP     = 2;

  localparam int unsigned DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;

  localparam int unsigned FB_ADDR_W = 22;
  localparam int unsigned PIX_W     = 16;
  localparam int unsigned LEN_W     = 9;

  localparam logic [FB_ADDR_W-1:0] DEF_FRAME_BASE = 22'd0;
  localparam logic [LEN_W-1:0]     DEF_BURST_LEN  = 9'd256;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    RUN        = 2'd2
  } rd_state_e;

endpackage

// File: rtl/lcd_frame_reader_if.sv
// Read-side link between the SDRAM frame buffer and the LCD frame reader.
interface lcd_frame_reader_if;
  import lcd_timing_pkg::*;

  logic                 sdram_init_done;
  logic [PIX_W-1:0]     sys_data_out;
  logic                 sys_rd;
  logic                 data_valid;
  logic                 rd_load;
  logic [FB_ADDR_W-1:0] rd_addr;
  logic [FB_ADDR_W-1:0] rd_max_addr;
  logic [LEN_W-1:0]     rd_length;

  modport master (
    input  sdram_init_done, sys_data_out,
    output sys_rd, data_valid, rd_load, rd_addr, rd_max_addr, rd_length
  );

  modport slave (
    output sdram_init_done, sys_data_out,
    input  sys_rd, data_valid, rd_load, rd_addr, rd_max_addr, rd_length
  );

endinterface

// File: rtl/lcd_sync_gen.sv
// Free-running raster counters with sync and active-area decode; no FIFO awareness.
module lcd_sync_gen
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_hs_raw,
  output logic o_vs_raw,
  output logic o_act,
  output logic o_frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  // One spare bit so the exclusive active-end bound always fits.
  localparam int unsigned HW = $clog2(H_TOTAL + 1);
  localparam int unsigned VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_E  = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_BEG = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_E  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_BEG = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_SYNC + V_BP + V_ACTIVE);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign o_hs_raw      = (r_h_cnt < H_SYNC_E);
  assign o_vs_raw      = (r_v_cnt < V_SYNC_E);
  assign o_act         = (r_h_cnt >= H_ACT_BEG) && (r_h_cnt < H_ACT_END) &&
                         (r_v_cnt >= V_ACT_BEG) && (r_v_cnt < V_ACT_END);
  assign o_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

// File: rtl/lcd_frame_reader.sv
// LCD panel driver that pops RGB565 pixels from the frame-buffer read FIFO in raster order.
module lcd_frame_reader
  import lcd_timing_pkg::*;
#(
  parameter int unsigned          H_SYNC     = DEF_H_SYNC,
  parameter int unsigned          H_BP       = DEF_H_BP,
  parameter int unsigned          H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned          H_FP       = DEF_H_FP,
  parameter int unsigned          V_SYNC     = DEF_V_SYNC,
  parameter int unsigned          V_BP       = DEF_V_BP,
  parameter int unsigned          V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned          V_FP       = DEF_V_FP,
  parameter bit                   SYNC_POL   = 1'b0,
  parameter logic [FB_ADDR_W-1:0] FRAME_BASE = DEF_FRAME_BASE,
  parameter logic [LEN_W-1:0]     BURST_LEN  = DEF_BURST_LEN
) (
  input  logic               clk,
  input  logic               rst_n,
  lcd_frame_reader_if.master fb_if,
  output logic               lcd_hs,
  output logic               lcd_vs,
  output logic               lcd_de,
  output logic [PIX_W-1:0]   lcd_rgb
);

  logic w_hs_raw, w_vs_raw, w_act, w_frame_start;

  lcd_sync_gen #(
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP)
  ) u_sync (
    .clk           (clk),
    .rst_n         (rst_n),
    .o_hs_raw      (w_hs_raw),
    .o_vs_raw      (w_vs_raw),
    .o_act         (w_act),
    .o_frame_start (w_frame_start)
  );

  rd_state_e r_state, w_state_d;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:       if (fb_if.sdram_init_done) w_state_d = WAIT_FRAME;
      WAIT_FRAME: if (w_frame_start) w_state_d = RUN;
      RUN:        w_state_d = RUN;
      default:    w_state_d = IDLE;
    endcase
    if (!fb_if.sdram_init_done) w_state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_d;
  end

  // r_de_pipe[0] doubles as the FIFO pop; [1] marks the cycle the popped word is valid.
  logic [2:0]       r_de_pipe;
  logic [2:0]       r_hs_pipe;
  logic [2:0]       r_vs_pipe;
  logic [PIX_W-1:0] r_rgb;
  logic             r_data_valid;
  logic             r_rd_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de_pipe    <= '0;
      r_hs_pipe    <= '0;
      r_vs_pipe    <= '0;
      r_rgb        <= '0;
      r_data_valid <= 1'b0;
      r_rd_load    <= 1'b0;
    end else begin
      r_de_pipe    <= {r_de_pipe[1:0], w_act && (w_state_d == RUN)};
      r_hs_pipe    <= {r_hs_pipe[1:0], w_hs_raw};
      r_vs_pipe    <= {r_vs_pipe[1:0], w_vs_raw};
      r_rgb        <= r_de_pipe[1] ? fb_if.sys_data_out : '0;
      r_data_valid <= (w_state_d == RUN);
      r_rd_load    <= w_frame_start && ((r_state == WAIT_FRAME) || (r_state == RUN));
    end
  end

  assign fb_if.sys_rd      = r_de_pipe[0];
  assign fb_if.data_valid  = r_data_valid;
  assign fb_if.rd_load     = r_rd_load;
  assign fb_if.rd_addr     = FRAME_BASE;
  assign fb_if.rd_max_addr = FRAME_BASE + FB_ADDR_W'(H_ACTIVE * V_ACTIVE);
  assign fb_if.rd_length   = BURST_LEN;

  assign lcd_hs  = r_hs_pipe[2] ^ ~SYNC_POL;
  assign lcd_vs  = r_vs_pipe[2] ^ ~SYNC_POL;
  assign lcd_de  = r_de_pipe[2];
  assign lcd_rgb = r_rgb;

endmodule

// File: tb/tb_lcd_frame_reader.sv
// Directed bench: small 16x8 raster DUT for FIFO/FSM behaviour, default DUT for real timing.
module tb_lcd_frame_reader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lcd_frame_reader_if fb ();
  lcd_frame_reader_if fb_def ();

  logic        lcd_hs, lcd_vs, lcd_de;
  logic [15:0] lcd_rgb;
  logic        def_hs, def_vs, def_de;
  logic [15:0] def_rgb;

  lcd_frame_reader #(
    .H_SYNC(4), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(2), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
    .SYNC_POL(1'b0), .FRAME_BASE(22'd100), .BURST_LEN(9'd256)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .fb_if(fb),
    .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de), .lcd_rgb(lcd_rgb)
  );

  lcd_frame_reader u_dut_def (
    .clk(clk), .rst_n(rst_n), .fb_if(fb_def),
    .lcd_hs(def_hs), .lcd_vs(def_vs), .lcd_de(def_de), .lcd_rgb(def_rgb)
  );

  assign fb_def.sdram_init_done = 1'b0;
  assign fb_def.sys_data_out    = 16'h0000;

  // FIFO model: incrementing words, each valid the cycle after its pop.
  logic [15:0] fifo_q = 16'hA000;
  always @(posedge clk) begin
    if (fb.sys_rd) begin
      fb.sys_data_out <= fifo_q;
      fifo_q          <= fifo_q + 16'd1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int   cyc;
  logic rd_hist [0:1023];

  initial begin
    int hs_f1, hs_f2, vs_f1, vs_f2, hs_low, a_rd, a_dv, a_de, a_rgb;
    logic hs_prev, vs_prev, dhs_prev, dvs_prev, shs_prev;
    int rl_b, rl_b_cyc, rl_c, rl_c_cyc, dv_first, rd_b, de_b, de_first, de_run, runs_b;
    int rd_gap, dv_gap, rgb_leak;
    int d_hf1, d_hr1, d_hf2, d_vf1, d_vr1, s_hf1, rl_d, d_de;
    logic [15:0] exp_pix;

    rst_n = 1'b0;
    fb.sdram_init_done = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_sys_rd", 32'(fb.sys_rd), 0);
    chk("rst_data_valid", 32'(fb.data_valid), 0);
    chk("rst_rd_load", 32'(fb.rd_load), 0);
    chk("rst_lcd_de", 32'(lcd_de), 0);
    chk("rst_lcd_rgb", 32'(lcd_rgb), 0);
    chk("rst_lcd_hs", 32'(lcd_hs), 1);
    chk("rst_lcd_vs", 32'(lcd_vs), 1);
    chk("rd_addr", 32'(fb.rd_addr), 100);
    chk("rd_max_addr", 32'(fb.rd_max_addr), 132);
    chk("rd_length", 32'(fb.rd_length), 256);
    chk("def_rd_addr", 32'(fb_def.rd_addr), 0);
    chk("def_rd_max_addr", 32'(fb_def.rd_max_addr), 130560);
    chk("def_rd_length", 32'(fb_def.rd_length), 256);

    // Init held low: syncs run, nothing is popped or displayed.
    rst_n = 1'b1;
    cyc = 0;
    hs_f1 = 0; hs_f2 = 0; vs_f1 = 0; vs_f2 = 0; hs_low = 0;
    a_rd = 0; a_dv = 0; a_de = 0; a_rgb = 0;
    hs_prev = lcd_hs; vs_prev = lcd_vs;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cyc++;
      if (fb.sys_rd) a_rd++;
      if (fb.data_valid) a_dv++;
      if (lcd_de) a_de++;
      if (lcd_rgb != 16'h0) a_rgb++;
      if (hs_prev && !lcd_hs) begin
        if (hs_f1 == 0) hs_f1 = cyc;
        else if (hs_f2 == 0) hs_f2 = cyc;
      end
      if (vs_prev && !lcd_vs) begin
        if (vs_f1 == 0) vs_f1 = cyc;
        else if (vs_f2 == 0) vs_f2 = cyc;
      end
      if (!lcd_hs && cyc >= 3 && cyc < 19) hs_low++;
      hs_prev = lcd_hs;
      vs_prev = lcd_vs;
    end
    chk("idle_sys_rd_count", a_rd, 0);
    chk("idle_data_valid_count", a_dv, 0);
    chk("idle_lcd_de_count", a_de, 0);
    chk("idle_rgb_nonzero", a_rgb, 0);
    chk("idle_hs_first_fall", hs_f1, 3);
    chk("idle_hs_period", hs_f2 - hs_f1, 16);
    chk("idle_hs_low_width", hs_low, 4);
    chk("idle_vs_first_fall", vs_f1, 3);
    chk("idle_vs_period", vs_f2 - vs_f1, 128);

    // Run frames, mid-line drop of init, re-entry at the next frame boundary.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    rl_b = 0; rl_b_cyc = 0; rl_c = 0; rl_c_cyc = 0; dv_first = 0; rd_b = 0; de_b = 0;
    de_first = 0; de_run = 0; runs_b = 0; rd_gap = 0; dv_gap = 0; rgb_leak = 0;
    exp_pix = 16'hA000;
    for (int i = 0; i < 444; i++) begin
      @(negedge clk);
      cyc++;
      rd_hist[cyc] = fb.sys_rd;
      if (fb.rd_load) begin
        if (cyc <= 256) begin rl_b++; rl_b_cyc = cyc; end
        else begin rl_c++; rl_c_cyc = cyc; end
      end
      if (fb.data_valid && dv_first == 0) dv_first = cyc;
      if (fb.sys_rd && cyc <= 258) rd_b++;
      if (cyc >= 314 && cyc <= 384) begin
        if (fb.sys_rd) rd_gap++;
        if (fb.data_valid) dv_gap++;
      end
      if (lcd_de) begin
        chk("pix_rgb", 32'(lcd_rgb), 32'(exp_pix));
        chk("pix_pop_lag", 32'(rd_hist[cyc-2]), 1);
        chk("pix_hs_idle", 32'(lcd_hs), 1);
        exp_pix = exp_pix + 16'd1;
        if (cyc <= 258) de_b++;
        if (de_first == 0) de_first = cyc;
        de_run++;
      end else begin
        if (lcd_rgb != 16'h0) rgb_leak++;
        if (de_run != 0) begin
          chk("de_run_len", de_run, (cyc == 316) ? 3 : 8);
          if (cyc <= 258) runs_b++;
        end
        de_run = 0;
      end
      if (cyc == 185) chk("f1_first_pix", 32'(lcd_rgb), 32'hA000);
      if (cyc == 441) chk("f3_first_pix", 32'(lcd_rgb), 32'hA023);
      if (cyc == 313) begin
        chk("drop_pre_sys_rd", 32'(fb.sys_rd), 1);
        chk("drop_pre_dv", 32'(fb.data_valid), 1);
      end
      if (cyc == 314) begin
        chk("drop_sys_rd", 32'(fb.sys_rd), 0);
        chk("drop_dv", 32'(fb.data_valid), 0);
      end
      if (cyc == 315) chk("drain_de", 32'(lcd_de), 1);
      if (cyc == 316) chk("drained_de", 32'(lcd_de), 0);
      if (cyc == 385) chk("rerun_dv", 32'(fb.data_valid), 1);
      if (cyc == 5) fb.sdram_init_done = 1'b1;
      if (cyc == 313) fb.sdram_init_done = 1'b0;
      if (cyc == 330) fb.sdram_init_done = 1'b1;
    end
    chk("first_rd_load_count", rl_b, 1);
    chk("first_rd_load_cycle", rl_b_cyc, 129);
    chk("first_dv_cycle", dv_first, 129);
    chk("frame1_pops", rd_b, 32);
    chk("frame1_de_count", de_b, 32);
    chk("frame1_first_de", de_first, 185);
    chk("frame1_lines", runs_b, 4);
    chk("rgb_leak_when_no_de", rgb_leak, 0);
    chk("gap_sys_rd", rd_gap, 0);
    chk("gap_dv", dv_gap, 0);
    chk("later_rd_load_count", rl_c, 2);
    chk("rerun_rd_load_cycle", rl_c_cyc, 385);

    // Asynchronous reset in the middle of an active line.
    chk("pre_rst_sys_rd", 32'(fb.sys_rd), 1);
    chk("pre_rst_de", 32'(lcd_de), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sys_rd", 32'(fb.sys_rd), 0);
    chk("arst_dv", 32'(fb.data_valid), 0);
    chk("arst_rd_load", 32'(fb.rd_load), 0);
    chk("arst_de", 32'(lcd_de), 0);
    chk("arst_rgb", 32'(lcd_rgb), 0);
    chk("arst_hs", 32'(lcd_hs), 1);
    chk("arst_vs", 32'(lcd_vs), 1);
    chk("arst_h_cnt", 32'(u_dut.u_sync.r_h_cnt), 0);
    chk("arst_v_cnt", 32'(u_dut.u_sync.r_v_cnt), 0);
    chk("arst_state", 32'(u_dut.r_state), 0);

    // Default timing on the full-size instance; small instance restarts cleanly.
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    d_hf1 = 0; d_hr1 = 0; d_hf2 = 0; d_vf1 = 0; d_vr1 = 0; s_hf1 = 0; rl_d = 0; d_de = 0;
    dhs_prev = def_hs; dvs_prev = def_vs; shs_prev = lcd_hs;
    for (int i = 0; i < 5300; i++) begin
      @(negedge clk);
      cyc++;
      if (dhs_prev && !def_hs) begin
        if (d_hf1 == 0) d_hf1 = cyc;
        else if (d_hf2 == 0) d_hf2 = cyc;
      end
      if (!dhs_prev && def_hs && d_hr1 == 0) d_hr1 = cyc;
      if (dvs_prev && !def_vs && d_vf1 == 0) d_vf1 = cyc;
      if (!dvs_prev && def_vs && d_vr1 == 0) d_vr1 = cyc;
      if (shs_prev && !lcd_hs && s_hf1 == 0) s_hf1 = cyc;
      if (fb.rd_load && rl_d == 0) rl_d = cyc;
      if (def_de) d_de++;
      dhs_prev = def_hs;
      dvs_prev = def_vs;
      shs_prev = lcd_hs;
    end
    chk("def_hs_first_fall", d_hf1, 3);
    chk("def_hs_low_width", d_hr1 - d_hf1, 41);
    chk("def_line_period", d_hf2 - d_hf1, 525);
    chk("def_vs_first_fall", d_vf1, 3);
    chk("def_vs_low_width", d_vr1 - d_vf1, 5250);
    chk("def_de_count", d_de, 0);
    chk("post_rst_hs_first_fall", s_hf1, 3);
    chk("post_rst_rd_load_cycle", rl_d, 129);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
